banked_word_mem: RTL and testbench

//  Parametrised word memory with a multi-bank byte array (BANKS x DEPTH x BYTE_W).

---
 rtl/banked_mem_pkg.sv | 18 +
 rtl/banked_word_mem_bank.sv | 22 ++
 rtl/banked_word_mem.sv | 104 ++++++++++
 tb/tb_banked_word_mem.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_mem_pkg.sv
// Shared types and default geometry for the banked word memory.
package banked_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DATA_W  = 32;
  localparam int DEPTH_W = $clog2(16);

  // Index width of a DEPTH-entry array, never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/banked_word_mem_bank.sv
// One byte lane of the word memory: synchronous write, registered read.
module mem_bank #(
  parameter int DEPTH  = 16,
  parameter int BYTE_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/banked_word_mem.sv
// Banked word memory with valid/ready request and response ports,
// byte-enabled single-beat writes and wrapping read bursts.
module banked_word_mem
  import banked_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int BYTE_W = 8,
  parameter int BANKS  = 4,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LEN_W-1:0]        req_len,
  input  logic [BANKS-1:0]        req_be,
  input  logic [BANKS*BYTE_W-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [BANKS*BYTE_W-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_last
);

  localparam int WORD_W = BANKS * BYTE_W;
  localparam int IDX_W  = idx_width(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state, state_nxt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    beats_q;
  logic [BANKS-1:0]    be_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   lane_rdata;
  logic                in_range, last_beat, req_fire, rsp_fire;
  logic                bank_we, bank_re;

  assign in_range  = {1'b0, addr_q} < DEPTH_LIM;
  // Writes and range errors always terminate after a single response.
  assign last_beat = we_q || !in_range || (beats_q == '0);
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = last_beat ? IDLE : ACCESS;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    bank_we   = (state == ACCESS) && we_q && in_range;
    bank_re   = (state == ACCESS) && !we_q && in_range;
    rsp_err   = (state == RESP) && !in_range;
    rsp_last  = (state == RESP) && last_beat;
    rsp_rdata = '0;
    if ((state == RESP) && !we_q && in_range) rsp_rdata = lane_rdata;
  end

  // Request fields are held here for the whole transaction; burst address steps on each handshake.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      beats_q <= req_len;
      be_q    <= req_be;
      wdata_q <= req_wdata;
    end else if (rsp_fire && !last_beat) begin
      addr_q  <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      beats_q <= beats_q - LEN_W'(1);
    end
  end

  for (genvar i = 0; i < BANKS; i++) begin : g_bank
    mem_bank #(
      .DEPTH  (DEPTH),
      .BYTE_W (BYTE_W),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we && be_q[i]),
      .re    (bank_re),
      .addr  (addr_q[IDX_W-1:0]),
      .wdata (wdata_q[i*BYTE_W +: BYTE_W]),
      .rdata (lane_rdata[i*BYTE_W +: BYTE_W])
    );
  end

endmodule

// File: tb/tb_banked_word_mem.sv
// Directed testbench for banked_word_mem with hand-computed expectations.
module tb_banked_word_mem;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [1:0]  req_len;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_last;

  int checks = 0;
  int errors = 0;

  banked_word_mem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a request until accepted; cyc = edges taken (1 when ready was already high).
  task automatic send_req(input logic we, input logic [15:0] addr, input logic [1:0] len,
                          input logic [3:0] be, input logic [31:0] wdata, output int cyc);
    logic r;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    req_be    = be;
    req_wdata = wdata;
    req_valid = 1'b1;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      r = req_ready;
      tick();
      cyc++;
      if (r) break;
    end
    req_valid = 1'b0;
    // Garbage on the request bus after acceptance must be ignored.
    req_addr  = 16'hBEEF;
    req_wdata = 32'hDEADBEEF;
    req_be    = 4'hF;
    req_len   = 2'd3;
    req_we    = 1'b1;
  endtask

  // Wait for a response beat, consume it; cyc = idle cycles before rsp_valid.
  task automatic get_rsp(output logic [31:0] data, output logic err, output logic last,
                         output int cyc, output bit ok);
    ok = 0;
    cyc = 0;
    data = '0;
    err = 1'b0;
    last = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin
        data = rsp_rdata;
        err  = rsp_err;
        last = rsp_last;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        ok = 1;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    bit quiet;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b rdata=%h err=%b last=%b, required 0/0/0/0",
               rsp_valid, rsp_rdata, rsp_err, rsp_last);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
    end
    quiet = 1;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid !== 1'b0) quiet = 0;
      tick();
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_idle: rsp_valid rose with no request, required 0");
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e, l; int c, rc; bit ok;
    send_req(1'b1, 16'd3, 2'd0, 4'b1111, 32'hA1B2C3D4, c);
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || rc != 1 || d !== 32'h0 || e !== 1'b0 || l !== 1'b1) begin
      errors++;
      $display("FAIL write_ack: ok=%0d lat=%0d rdata=%h err=%b last=%b, required 1/1/0/0/1",
               ok, rc, d, e, l);
    end
    send_req(1'b0, 16'd3, 2'd0, 4'b0000, 32'h0, c);
    checks++;
    if (c != 1) begin
      errors++;
      $display("FAIL back_to_back_accept: accept cycles=%0d, required 1", c);
    end
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || rc != 1 || d !== 32'hA1B2C3D4 || e !== 1'b0 || l !== 1'b1) begin
      errors++;
      $display("FAIL read_full: ok=%0d lat=%0d rdata=%h err=%b last=%b, required 1/1/a1b2c3d4/0/1",
               ok, rc, d, e, l);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d; logic e, l; int c, rc; bit ok;
    send_req(1'b1, 16'd3, 2'd0, 4'b0001, 32'h00000055, c);
    get_rsp(d, e, l, rc, ok);
    send_req(1'b0, 16'd3, 2'd0, 4'b0000, 32'h0, c);
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || d !== 32'hA1B2C355) begin
      errors++;
      $display("FAIL byte_enable: ok=%0d rdata=%h, required a1b2c355", ok, d);
    end
    send_req(1'b1, 16'd3, 2'd0, 4'b0000, 32'hFFFFFFFF, c);
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || e !== 1'b0 || l !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL be_zero_ack: ok=%0d err=%b last=%b rdata=%h, required 1/0/1/0", ok, e, l, d);
    end
    send_req(1'b0, 16'd3, 2'd0, 4'b0000, 32'h0, c);
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || d !== 32'hA1B2C355) begin
      errors++;
      $display("FAIL be_zero_noop: ok=%0d rdata=%h, required a1b2c355", ok, d);
    end
  endtask

  task automatic test_wrap_burst();
    logic [31:0] d, held; logic e, l; int c, rc; bit ok, stable;
    logic [15:0] waddr [4];
    waddr[0] = 16'd14; waddr[1] = 16'd15; waddr[2] = 16'd0; waddr[3] = 16'd1;
    for (int i = 0; i < 4; i++) begin
      send_req(1'b1, waddr[i], 2'd0, 4'b1111, 32'(waddr[i]), c);
      get_rsp(d, e, l, rc, ok);
    end
    send_req(1'b0, 16'd14, 2'd3, 4'b0000, 32'h0, c);
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || d !== 32'd14 || l !== 1'b0 || e !== 1'b0) begin
      errors++;
      $display("FAIL burst_beat1: ok=%0d rdata=%h last=%b err=%b, required 1/0000000e/0/0", ok, d, l, e);
    end
    for (int k = 0; k < 20 && !rsp_valid; k++) tick();
    held = rsp_rdata;
    stable = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || rsp_last !== 1'b0) stable = 0;
    end
    checks++;
    if (!stable || held !== 32'd15) begin
      errors++;
      $display("FAIL burst_hold: stable=%0d rdata=%h now=%h, required 1/0000000f", stable, held, rsp_rdata);
    end
    get_rsp(d, e, l, rc, ok);
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || rc != 1 || d !== 32'd0 || l !== 1'b0) begin
      errors++;
      $display("FAIL burst_beat3: ok=%0d lat=%0d rdata=%h last=%b, required 1/1/0/0", ok, rc, d, l);
    end
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || d !== 32'd1 || l !== 1'b1) begin
      errors++;
      $display("FAIL burst_beat4: ok=%0d rdata=%h last=%b, required 1/00000001/1", ok, d, l);
    end
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (ok) begin
      errors++;
      $display("FAIL burst_extra: stray beat rdata=%h, required none", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic e, l; int c, rc; bit ok;
    send_req(1'b0, 16'd16, 2'd2, 4'b0000, 32'h0, c);
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || e !== 1'b1 || d !== 32'h0 || l !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: ok=%0d err=%b rdata=%h last=%b, required 1/1/0/1", ok, e, d, l);
    end
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (ok || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_single: extra=%0d req_ready=%b, required 0/1", ok, req_ready);
    end
    send_req(1'b1, 16'd19, 2'd0, 4'b1111, 32'h12345678, c);
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || e !== 1'b1 || d !== 32'h0 || l !== 1'b1) begin
      errors++;
      $display("FAIL oor_write: ok=%0d err=%b rdata=%h last=%b, required 1/1/0/1", ok, e, d, l);
    end
    send_req(1'b0, 16'd3, 2'd0, 4'b0000, 32'h0, c);
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || d !== 32'hA1B2C355) begin
      errors++;
      $display("FAIL oor_unchanged: rdata=%h, required a1b2c355", d);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d; logic e, l; int c, rc; bit ok, quiet;
    send_req(1'b0, 16'd0, 2'd3, 4'b0000, 32'h0, c);
    get_rsp(d, e, l, rc, ok);
    for (int k = 0; k < 20 && !rsp_valid; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort: rsp_valid=%b rdata=%h, required 0/0", rsp_valid, rsp_rdata);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort_ready: req_ready=%b, required 1", req_ready);
    end
    quiet = 1;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid !== 1'b0) quiet = 0;
      tick();
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_abort_stray: stray beat after reset, required none");
    end
    send_req(1'b0, 16'd15, 2'd0, 4'b0000, 32'h0, c);
    get_rsp(d, e, l, rc, ok);
    checks++;
    if (!ok || d !== 32'd15 || l !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_read: ok=%0d rdata=%h last=%b err=%b, required 1/0000000f/1/0", ok, d, l, e);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_be    = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    #1;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_wrap_burst();
    test_out_of_range();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
